fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch controller for the single-issue MIPS pipeline. It owns the program counter and drives the address into the combinational instruction memory. It captures the returned word into the IF/ID pipeline register. It also handles pipeline stalls from the hazard unit and branch/jump redirects from EX, inserting NOP bubbles so software no longer needs hand-placed stall instructions.

Parameters:
RESET_PC, 32'd100, PC value loaded on reset (first fetch address)
NOP_INSTR, 32'h00000000, word placed in IF/ID on bubble (sll $0,$0,0)
PC_STEP, 32'd4, sequential increment

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_in  in  1  hazard unit: hold PC and IF/ID this cycle
redirect_valid  in  1  EX stage: branch taken or jump, load redirect_pc
redirect_pc  in  32  target address
imem_instr  in  32  combinational instruction word for pc_out, valid same cycle
pc_out  out  32  fetch address to instruction memory (= PC register)
ifid_instr  out  32  IF/ID instruction register
ifid_pc4  out  32  IF/ID PC+4 register
ifid_valid  out  1  IF/ID holds a real fetched instruction
fsm_state  out  2  00 BOOT, 01 RUN, 10 STALL, 11 FLUSH
misalign_err  out  1  sticky: a redirect target had nonzero bits [1:0]
fetch_count  out  32  instructions captured into IF/ID, saturating
bubble_count  out  16  bubble/hold cycles, saturating

Behaviour:
- Reset (synchronous, evaluated at clk edge, overrides all):
  - pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0.
  - fsm_state=BOOT, misalign_err=0, both counters 0.
  - Reset asserted mid-stall or mid-redirect discards all pending state.
- Priority each cycle: reset > redirect_valid > stall_in > normal fetch.
- Normal fetch (no stall, no redirect):
  - ifid_instr<=imem_instr, ifid_pc4<=pc+PC_STEP, ifid_valid<=1.
  - pc<=pc+PC_STEP; fetch_count+1.
  - Latency: address-to-IF/ID is one edge.
- Stall (stall_in=1, redirect_valid=0):
  - pc, ifid_instr, ifid_pc4 and ifid_valid all hold.
  - bubble_count+1.
- Redirect (redirect_valid=1, regardless of stall_in):
  - pc<={redirect_pc[31:2],2'b00}.
  - ifid_instr<=NOP_INSTR, ifid_valid<=0; ifid_pc4 holds.
  - bubble_count+1; misalign_err<=1 if redirect_pc[1:0]!=0.
  - The wrong-path word on imem_instr is discarded.
- FSM transitions (evaluated after reset):
  - BOOT: IF/ID empty. Normal fetch->RUN; stall->BOOT; redirect->FLUSH.
  - RUN: normal->RUN; stall->STALL; redirect->FLUSH.
  - STALL: normal->RUN; stall->STALL; redirect->FLUSH.
  - FLUSH: IF/ID holds a bubble. Normal->RUN (first target word captured); stall->FLUSH (bubble held, pc held); redirect->FLUSH (new target replaces old).
- Arithmetic:
  - pc+PC_STEP is modulo 2^32: 32'hFFFFFFFC wraps to 0 with no error.
  - Counters saturate at all-ones and do not wrap.
- pc_out is a direct register output with no combinational path from any input.
- ifid_valid is 0 exactly when ifid_instr is a bubble inserted by this block.

Test Plan:
1. Reset 2 cycles, release; IMEM returns 32'h00221820 at 100 -> pc_out=100 in BOOT; after 1 edge: ifid_instr=32'h00221820, ifid_pc4=104, ifid_valid=1, pc_out=104, state RUN, fetch_count=1.
2. Run to pc=116, assert stall_in 2 cycles -> pc_out stays 116, IF/ID unchanged, state STALL, bubble_count=2. Release -> ifid_instr=32'h01232022, pc_out=120.
3. At pc=124 assert redirect_valid with redirect_pc=100 and stall_in=1 -> next: pc_out=100, ifid_valid=0, ifid_instr=0, state FLUSH. Next edge: ifid_instr=32'h00221820, state RUN.
4. Redirect to 32'h00000066 -> pc_out=32'h00000064, misalign_err=1. Flag remains 1 through later fetches until reset.
5. Redirect to 32'hFFFFFFFC, then one normal fetch -> ifid_pc4=0, pc_out=0, no error.
6. Assert reset during a stall at pc=120 -> next edge: pc_out=100, ifid_valid=0, state BOOT, counters 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller for a single-issue MIPS pipeline. It owns the
// program counter and drives the combinational instruction memory. It captures
// the returned word into the IF/ID pipeline register. It honours hazard stalls
// and turns EX-stage redirects (taken branch / jump) into a NOP bubble, so
// software does not need hand-placed stall instructions.
//
// Ports
//   clk            in   system clock, all state updates on rising edge
//   reset          in   synchronous active-high reset, overrides everything
//   stall_in       in   hold PC and IF/ID this cycle
//   redirect_valid in   load redirect_pc (wins over stall_in)
//   redirect_pc    in   redirect target, low two bits forced to zero
//   imem_instr     in   instruction word for pc_out, valid in the same cycle
//   pc_out         out  fetch address (PC register, no input-to-output path)
//   ifid_instr     out  IF/ID instruction register
//   ifid_pc4       out  IF/ID PC+4 register
//   ifid_valid     out  IF/ID holds a real fetched instruction
//   fsm_state      out  00 BOOT, 01 RUN, 10 STALL, 11 FLUSH
//   misalign_err   out  sticky flag: some redirect target was not word aligned
//   fetch_count    out  instructions captured into IF/ID (saturating)
//   bubble_count   out  stall / redirect bubble cycles (saturating)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'd100,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [1:0]  fsm_state,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic [15:0] bubble_count
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_RUN   = 2'b01,
        S_STALL = 2'b10,
        S_FLUSH = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [15:0] bubble_count_q, bubble_count_d;

    // Sequential successor; wraps modulo 2^32 by construction.
    logic [31:0] pc_next_seq;
    assign pc_next_seq = pc_q + PC_STEP;

    // Saturating increments: the counters stick at all-ones.
    logic [31:0] fetch_count_inc;
    logic [15:0] bubble_count_inc;
    assign fetch_count_inc  = (&fetch_count_q)  ? fetch_count_q  : fetch_count_q + 32'd1;
    assign bubble_count_inc = (&bubble_count_q) ? bubble_count_q : bubble_count_q + 16'd1;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc4_d     = ifid_pc4_q;
        ifid_valid_d   = ifid_valid_q;
        misalign_d     = misalign_q;
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;

        if (redirect_valid) begin
            // The word on imem_instr is wrong-path and is dropped. ifid_pc4
            // keeps its old value, because ifid_valid=0 marks the slot as a bubble.
            pc_d           = {redirect_pc[31:2], 2'b00};
            ifid_instr_d   = NOP_INSTR;
            ifid_valid_d   = 1'b0;
            bubble_count_d = bubble_count_inc;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            state_d = S_FLUSH;
        end else if (stall_in) begin
            bubble_count_d = bubble_count_inc;
            // BOOT and FLUSH keep their identity while held, because IF/ID
            // still has no real instruction. A hold after real fetches is STALL.
            case (state_q)
                S_RUN, S_STALL: state_d = S_STALL;
                default:        state_d = state_q;
            endcase
        end else begin
            ifid_instr_d  = imem_instr;
            ifid_pc4_d    = pc_next_seq;
            ifid_valid_d  = 1'b1;
            pc_d          = pc_next_seq;
            fetch_count_d = fetch_count_inc;
            state_d       = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_PC;
            ifid_instr_q   <= NOP_INSTR;
            ifid_pc4_q     <= 32'd0;
            ifid_valid_q   <= 1'b0;
            misalign_q     <= 1'b0;
            fetch_count_q  <= 32'd0;
            bubble_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc4_q     <= ifid_pc4_d;
            ifid_valid_q   <= ifid_valid_d;
            misalign_q     <= misalign_d;
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign pc_out       = pc_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_pc4     = ifid_pc4_q;
    assign ifid_valid   = ifid_valid_q;
    assign fsm_state    = state_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. Each step drives one cycle of stimulus.
// It advances a reference model and pushes the expected post-edge outputs
// into a queue. After the edge, it pops that entry and compares it with the
// DUT. Fixed checkpoints repeat the literal values from the bring-up scenarios.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [1:0]  fsm_state;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [15:0] bubble_count;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_instr     (imem_instr),
        .pc_out         (pc_out),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .fsm_state      (fsm_state),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count),
        .bubble_count   (bubble_count)
    );

    // Small instruction ROM; any address not listed gets a distinct word.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'd100: imem = 32'h0022_1820;
            32'd116: imem = 32'h0123_2022;
            default: imem = {a[15:0], 16'hC0DE};
        endcase
    endfunction

    assign imem_instr = imem(pc_out);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        v;
        logic [1:0]  st;
        logic        mis;
        logic [31:0] fc;
        logic [15:0] bc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (values after the most recent edge).
    logic [31:0] m_pc    = 32'd100;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pc4   = 32'd0;
    logic        m_v     = 1'b0;
    logic [1:0]  m_st    = 2'b00;
    logic        m_mis   = 1'b0;
    logic [31:0] m_fc    = 32'd0;
    logic [15:0] m_bc    = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: update the model, queue the expectation, clock,
    // then check the DUT against the popped entry.
    task automatic step(input logic rst, input logic stl, input logic rv,
                        input logic [31:0] rpc);
        exp_t e;
        reset = rst; stall_in = stl; redirect_valid = rv; redirect_pc = rpc;
        if (rst) begin
            m_pc = 32'd100; m_instr = 32'd0; m_pc4 = 32'd0; m_v = 1'b0;
            m_st = 2'b00; m_mis = 1'b0; m_fc = 32'd0; m_bc = 16'd0;
        end else if (rv) begin
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
            m_pc = rpc & 32'hFFFF_FFFC;
            m_instr = 32'd0; m_v = 1'b0; m_st = 2'b11;
            if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
        end else if (stl) begin
            if (m_st == 2'b01) m_st = 2'b10;
            if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
        end else begin
            m_instr = imem(m_pc);
            m_pc = m_pc + 32'd4;
            m_pc4 = m_pc; m_v = 1'b1; m_st = 2'b01;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.v = m_v;
        e.st = m_st; e.mis = m_mis; e.fc = m_fc; e.bc = m_bc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pc_out",       pc_out,       e.pc);
        chk("ifid_instr",   ifid_instr,   e.instr);
        chk("ifid_pc4",     ifid_pc4,     e.pc4);
        chk("ifid_valid",   {31'd0, ifid_valid},   {31'd0, e.v});
        chk("fsm_state",    {30'd0, fsm_state},    {30'd0, e.st});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        chk("fetch_count",  fetch_count,  e.fc);
        chk("bubble_count", {16'd0, bubble_count}, {16'd0, e.bc});
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

        // Scenario 1: reset, then the first fetch.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("boot_pc",    pc_out, 32'd100);
        chk("boot_state", {30'd0, fsm_state}, 32'd0);
        chk("boot_imem",  imem_instr, 32'h0022_1820);
        step(0, 0, 0, 0);
        chk("f1_instr", ifid_instr, 32'h0022_1820);
        chk("f1_pc4",   ifid_pc4, 32'd104);
        chk("f1_pc",    pc_out, 32'd104);
        chk("f1_state", {30'd0, fsm_state}, 32'd1);
        chk("f1_fc",    fetch_count, 32'd1);

        // Scenario 2: run to 116, stall twice, then release.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("stall_pc",    pc_out, 32'd116);
        chk("stall_state", {30'd0, fsm_state}, 32'd2);
        chk("stall_bc",    {16'd0, bubble_count}, 32'd2);
        step(0, 0, 0, 0);
        chk("rel_instr", ifid_instr, 32'h0123_2022);
        chk("rel_pc",    pc_out, 32'd120);

        // Scenario 3: redirect wins over a stall, then capture the target word.
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'd100);
        chk("rd_pc",    pc_out, 32'd100);
        chk("rd_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rd_instr", ifid_instr, 32'd0);
        chk("rd_state", {30'd0, fsm_state}, 32'd3);
        step(0, 1, 0, 0);               // a stall in FLUSH keeps the bubble
        chk("fl_hold_state", {30'd0, fsm_state}, 32'd3);
        step(0, 0, 0, 0);
        chk("rd2_instr", ifid_instr, 32'h0022_1820);
        chk("rd2_state", {30'd0, fsm_state}, 32'd1);

        // Scenario 4: a misaligned target sets the sticky flag.
        step(0, 0, 1, 32'h0000_0066);
        chk("mis_pc",  pc_out, 32'h0000_0064);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

        // Scenario 5: wrap at the top of the address space (after a fresh reset).
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);               // stall in BOOT stays BOOT
        chk("boot_hold", {30'd0, fsm_state}, 32'd0);
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_pc4", ifid_pc4, 32'd0);
        chk("wrap_pc",  pc_out, 32'd0);
        chk("wrap_err", {31'd0, misalign_err}, 32'd0);

        // Scenario 6: reset during a stall at pc=120.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("pre_rst_pc", pc_out, 32'd120);
        step(1, 1, 0, 0);
        chk("rst_pc",    pc_out, 32'd100);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_state", {30'd0, fsm_state}, 32'd0);
        chk("rst_fc",    fetch_count, 32'd0);
        chk("rst_bc",    {16'd0, bubble_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
